// File: rtl/mdu_pkg.sv
// mdu_pkg: way encodings, FSM states and default latencies for the multiply/divide unit
package mdu_pkg;
  localparam logic [2:0] WAY_MULT  = 3'b001;
  localparam logic [2:0] WAY_MULTU = 3'b010;
  localparam logic [2:0] WAY_DIV   = 3'b011;
  localparam logic [2:0] WAY_DIVU  = 3'b100;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic is_valid_way(input logic [2:0] w);
    return w == WAY_MULT || w == WAY_MULTU || w == WAY_DIV || w == WAY_DIVU;
  endfunction
  function automatic logic is_div_way(input logic [2:0] w);
    return w == WAY_DIV || w == WAY_DIVU;
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64b product or quotient/remainder for the selected way, plus divide-by-zero flag
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_way,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div0
);
  logic [63:0] w_sprod, w_uprod;
  logic [31:0] w_ua, w_ub, w_dv, w_q, w_r, w_sq, w_sr;
  logic        w_sgn;
  always_comb begin
    w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    w_uprod = {32'b0, i_a} * {32'b0, i_b};
    w_sgn   = i_way == WAY_DIV;
    // divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without a signed overflow
    w_ua    = w_sgn && i_a[31] ? -i_a : i_a;
    w_ub    = w_sgn && i_b[31] ? -i_b : i_b;
    w_dv    = i_b == 32'b0 ? 32'd1 : w_ub;
    w_q     = w_ua / w_dv;
    w_r     = w_ua % w_dv;
    w_sq    = w_sgn && (i_a[31] ^ i_b[31]) ? -w_q : w_q;
    w_sr    = w_sgn && i_a[31] ? -w_r : w_r;
    o_hi    = i_way == WAY_MULT ? w_sprod[63:32] : i_way == WAY_MULTU ? w_uprod[63:32] : w_sr;
    o_lo    = i_way == WAY_MULT ? w_sprod[31:0] : i_way == WAY_MULTU ? w_uprod[31:0] : w_sq;
    o_div0  = is_div_way(i_way) && i_b == 32'b0;
  end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage mult/div sequencer with HI/LO, mthi/mtlo, mfhi/mflo readout and stall request
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  way,
  input  logic        md,
  input  logic        HIw,
  input  logic        LOw,
  input  logic        mh,
  input  logic        ml,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] out
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi, r_lo, r_thi, r_tlo;
  logic        r_div0, r_busy;
  logic [31:0] w_hi, w_lo;
  logic        w_div0, w_go;
  mdu_arith u_arith (
    .i_way (way),
    .i_a   (a),
    .i_b   (b),
    .o_hi  (w_hi),
    .o_lo  (w_lo),
    .o_div0(w_div0)
  );
  assign w_go  = start && !req && is_valid_way(way);
  assign busy  = r_busy;
  assign stall = md && (start || r_busy);
  assign out   = mh ? r_hi : ml ? r_lo : 32'b0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_thi   <= '0;
      r_tlo   <= '0;
      r_div0  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_go) begin
        r_state <= RUN;
        r_busy  <= 1'b1;
        r_cnt   <= is_div_way(way) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        r_thi   <= w_hi;
        r_tlo   <= w_lo;
        r_div0  <= w_div0;
      end else if (!req) begin
        if (HIw) r_hi <= a;
        if (LOw) r_lo <= a;
      end
    end else begin
      r_cnt <= r_cnt - 1'b1;
      // commit on the edge where the counter reaches zero; a divide by zero leaves HI/LO alone
      if (r_cnt == CW'(1)) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        if (!r_div0) begin
          r_hi <= r_thi;
          r_lo <= r_tlo;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vectors checked against a cycle model plus literal HI/LO/latency expectations
module tb_mdu_sequencer;
  logic clk = 0, reset = 1, req = 0, start = 0, md = 0, HIw = 0, LOw = 0, mh = 0, ml = 0;
  logic [2:0] way = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, stall;
  logic [31:0] out;
  int n_cmp = 0, n_bad = 0;
  bit armed = 0;
  mdu_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .way(way), .md(md),
    .HIw(HIw), .LOw(LOw), .mh(mh), .ml(ml), .a(a), .b(b),
    .busy(busy), .stall(stall), .out(out)
  );
  always #5 clk = ~clk;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit p_keep = 0;
  int m_left = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  // result of one operation from plain integer arithmetic
  task automatic calc(input logic [2:0] w, input logic [31:0] x, input logic [31:0] y,
                      output logic [31:0] h, output logic [31:0] l, output bit keep);
    int sx, sy;
    longint p;
    sx = x; sy = y; keep = 0; h = 0; l = 0;
    if (w == 3'b001) begin p = longint'(sx) * longint'(sy); {h, l} = p; end
    else if (w == 3'b010) begin p = longint'({32'b0, x}) * longint'({32'b0, y}); {h, l} = p; end
    else if (y == 0) keep = 1;
    else if (w == 3'b011) begin
      if (x == 32'h8000_0000 && sy == -1) begin l = x; h = 0; end
      else begin l = sx / sy; h = sx % sy; end
    end else begin l = x / y; h = x % y; end
  endtask
  always @(posedge clk) begin
    if (reset) begin m_hi = 0; m_lo = 0; m_left = 0; end
    else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !p_keep) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (start && !req && way >= 3'd1 && way <= 3'd4) begin
      calc(way, a, b, p_hi, p_lo, p_keep);
      m_left = way >= 3'd3 ? 10 : 5;
    end else if (!req) begin
      if (HIw) m_hi = a;
      if (LOw) m_lo = a;
    end
  end
  always @(negedge clk) if (armed) begin
    chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
    chk("stall", {31'b0, stall}, {31'b0, md && (start || m_left > 0)});
    chk("out", out, mh ? m_hi : ml ? m_lo : 32'b0);
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rd(input string nm, input logic [31:0] eh, input logic [31:0] el);
    mh = 1; #1 chk({nm, ".hi"}, out, eh);
    mh = 0; ml = 1; #1 chk({nm, ".lo"}, out, el);
    ml = 0;
  endtask
  task automatic run(input string nm, input logic [2:0] w, input logic [31:0] x, input logic [31:0] y, input int lat);
    int k;
    way = w; a = x; b = y; start = 1;
    cyc(1);
    start = 0;
    k = 0;
    while (busy === 1'b1 && k < 40) begin k++; cyc(1); end
    chk({nm, ".lat"}, k, lat);
  endtask
  initial begin
    cyc(2);
    reset = 0;
    armed = 1;
    chk("rst.busy", {31'b0, busy}, 0);
    chk("rst.stall", {31'b0, stall}, 0);
    rd("rst", 0, 0);
    run("mult", 3'b001, -32'sd3, 32'd7, 5);
    rd("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("multu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5);
    rd("multu", 32'd1, 32'hFFFF_FFFE);
    run("div", 3'b011, -32'sd7, 32'd2, 10);
    rd("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    a = 32'h11; HIw = 1; cyc(1); HIw = 0;
    a = 32'h22; LOw = 1; cyc(1); LOw = 0;
    rd("mt", 32'h11, 32'h22);
    run("div0", 3'b011, 32'd5, 32'd0, 10);
    rd("div0", 32'h11, 32'h22);
    run("ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    rd("ovf", 32'h0, 32'h8000_0000);
    req = 1; way = 3'b001; a = 2; b = 3; start = 1; cyc(1); start = 0;
    chk("req.busy", {31'b0, busy}, 0);
    a = 32'h55; HIw = 1; cyc(1); HIw = 0; req = 0;
    rd("req", 32'h0, 32'h8000_0000);
    way = 3'b000; start = 1; cyc(1); start = 0;
    chk("badway.busy", {31'b0, busy}, 0);
    way = 3'b100; a = 32'h77; b = 0; HIw = 1; start = 1; cyc(1); start = 0; HIw = 0;
    chk("startwins.busy", {31'b0, busy}, 1);
    cyc(10);
    rd("startwins", 32'h0, 32'h8000_0000);
    md = 1; mh = 1; way = 3'b100; a = 100; b = 7; start = 1; cyc(1); start = 0;
    cyc(2);
    a = 32'h99; HIw = 1; req = 1; cyc(1); HIw = 0; req = 0;
    way = 3'b001; a = 9; b = 9; start = 1; cyc(1); start = 0;
    cyc(5);
    chk("mf.busy_last", {31'b0, busy}, 1);
    chk("mf.stall_last", {31'b0, stall}, 1);
    cyc(1);
    chk("mf.out", out, 32'd2);
    chk("mf.stall", {31'b0, stall}, 0);
    md = 0; mh = 0;
    rd("mf", 32'd2, 32'd14);
    way = 3'b011; a = 50; b = 5; start = 1; cyc(1); start = 0;
    cyc(2);
    reset = 1; cyc(1); reset = 0;
    chk("rstmid.busy", {31'b0, busy}, 0);
    rd("rstmid", 0, 0);
    run("after", 3'b001, 32'd6, 32'd7, 5);
    rd("after", 0, 32'd42);
    cyc(2);
    armed = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
